pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter: PREAMBLE, 4'b1101, preamble pattern sent MSB first at the start of every frame.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to send a burst; sampled on rising clk.
REQ-005 data  input  4  payload nibble; captured only when start is accepted.
REQ-006 repeat  input  2  burst length minus one (frames = repeat+1); captured with data.
REQ-007 ser_out  output  1  registered serial bit stream to the 1101 detector.
REQ-008 busy  output  1  high while a burst is being transmitted.
REQ-009 done  output  1  one-cycle pulse after the last bit of a burst.
REQ-010 frame_idx  output  2  index of the frame currently on ser_out (0-based).

Function
REQ-011 Frame format SHALL be 9 bits, MSB first: PREAMBLE[3:0], then data[3:0], then even parity bit = XOR of data[3:0].
REQ-012 The FSM SHALL have the states IDLE, PRE, DATA, PAR and GAP; all outputs SHALL be registered.
REQ-013 In IDLE, start=1 at a clk edge SHALL be accepted and SHALL latch data and repeat; state moves to PRE.
REQ-014 The first preamble bit SHALL appear on ser_out with busy=1 in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-015 PRE SHALL last 4 cycles, DATA 4 cycles and PAR 1 cycle, emitting one bit per cycle; a 2-bit bit counter SHALL sequence PRE and DATA.
REQ-016 After PAR, if frame_idx < latched repeat, the FSM SHALL enter GAP for exactly 1 cycle (ser_out=0, busy=1), increment frame_idx, then re-enter PRE.
REQ-017 After PAR of the final frame, the FSM SHALL return to IDLE; in the following cycle done=1, busy=0, ser_out=0 and frame_idx=0.
REQ-018 done SHALL be high for exactly one cycle per completed burst and never otherwise.
REQ-019 start while busy=1 SHALL be ignored, with no queuing; changes to data or repeat mid-burst SHALL have no effect.
REQ-020 start=1 in the done cycle SHALL be accepted (back-to-back bursts); the next frame's first bit follows one cycle later.
REQ-021 In IDLE, ser_out SHALL be held at 0.
REQ-022 Burst length SHALL be 9*(repeat+1) + repeat cycles of busy=1.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, ser_out=0, busy=0, done=0, frame_idx=0, bit counter=0 and latched data/repeat=0.
REQ-024 Reset mid-burst SHALL abort the burst with no done pulse; start is ignored while reset=1.
REQ-025 After reset deasserts, the first clk edge with start=1 SHALL be accepted normally.

Verification
REQ-026 data=4'b1010, repeat=0, start pulse at edge 0 -> ser_out cycles 1-9 = 1,1,0,1,1,0,1,0,0; busy cycles 1-9; done=1 only in cycle 10.
REQ-027 data=4'b0111, repeat=0 -> ser_out = 1,1,0,1,0,1,1,1,1 (parity 1).
REQ-028 data=4'b0001, repeat=2 -> three frames 110100011, each separated by one 0 gap cycle; frame_idx 0/1/2; busy cycles 1-29; done in cycle 30.
REQ-029 reset asserted asynchronously during cycle 5 of a frame -> ser_out=0 and busy=0 before the next edge; no done; a new start afterwards yields a full correct frame.
REQ-030 start held high throughout a burst with data changing -> no restart and no payload change; a new burst starts only from the done cycle, with first bit in the following cycle.
REQ-031 Loopback into the 1101 Mealy detector with data=4'b1101, repeat=0 -> the detector flags the preamble and the payload occurrences; the bench checks both detections at the expected cycles.

Source files
------------

// File: rtl/pattern_tx.sv
// Serial burst transmitter: each frame is a 4-bit preamble, a 4-bit payload and
// an even parity bit, MSB first. A burst is repeat+1 frames with one idle gap bit between frames.
module pattern_tx #(
  parameter logic [3:0] PREAMBLE = 4'b1101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [3:0] data_i,
  input  logic [1:0] repeat_i,
  output logic       ser_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] frame_idx_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAR,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] bitCnt_q, bitCnt_d;
  logic [1:0] frameIdx_q, frameIdx_d;
  logic [3:0] data_q, data_d;
  logic [1:0] repeat_q, repeat_d;
  logic       serOut_q, serOut_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] nextBit;

  // Bit k of a 4-bit field goes out MSB first, so the field index is ~k.
  assign nextBit = bitCnt_q + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= 2'd0;
      frameIdx_q <= 2'd0;
      data_q     <= 4'd0;
      repeat_q   <= 2'd0;
      serOut_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      frameIdx_q <= frameIdx_d;
      data_q     <= data_d;
      repeat_q   <= repeat_d;
      serOut_q   <= serOut_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are computed for the state being entered, so they line up with it after the edge.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    frameIdx_d = frameIdx_q;
    data_d     = data_q;
    repeat_d   = repeat_q;
    serOut_d   = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        frameIdx_d = 2'd0;
        if (start_i) begin
          state_d  = PRE;
          bitCnt_d = 2'd0;
          data_d   = data_i;
          repeat_d = repeat_i;
          serOut_d = PREAMBLE[3];
          busy_d   = 1'b1;
        end
      end
      PRE: begin
        if (bitCnt_q == 2'd3) begin
          state_d  = DATA;
          bitCnt_d = 2'd0;
          serOut_d = data_q[3];
        end else begin
          bitCnt_d = nextBit;
          serOut_d = PREAMBLE[~nextBit];
        end
      end
      DATA: begin
        if (bitCnt_q == 2'd3) begin
          state_d  = PAR;
          bitCnt_d = 2'd0;
          serOut_d = ^data_q;
        end else begin
          bitCnt_d = nextBit;
          serOut_d = data_q[~nextBit];
        end
      end
      PAR: begin
        if (frameIdx_q < repeat_q) begin
          state_d = GAP;
        end else begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          frameIdx_d = 2'd0;
        end
      end
      GAP: begin
        state_d    = PRE;
        bitCnt_d   = 2'd0;
        frameIdx_d = frameIdx_q + 2'd1;
        serOut_d   = PREAMBLE[3];
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ser_out_o   = serOut_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_idx_o = frameIdx_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: a queue-based burst model checked every cycle,
// plus directed bursts with hand-computed bit streams and a 1101 detector on the loopback.
module tb_pattern_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] data;
  logic [1:0] rep;
  logic       ser;
  logic       busy;
  logic       done;
  logic [1:0] fidx;

  int checks = 0;
  int errors = 0;

  pattern_tx #(.PREAMBLE(4'b1101)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .data_i     (data),
    .repeat_i   (rep),
    .ser_out_o  (ser),
    .busy_o     (busy),
    .done_o     (done),
    .frame_idx_o(fidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ser;
    logic       busy;
    logic       done;
    logic [1:0] fidx;
  } outT;

  outT expQ[$];
  outT cur;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: an accepted burst expands into its full list of per-cycle outputs.
  initial begin
    logic [8:0] frame;
    cur = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        expQ.delete();
        cur = '0;
      end else begin
        if (start && !cur.busy) begin
          frame = {4'b1101, data, ^data};
          for (int f = 0; f <= int'(rep); f++) begin
            for (int b = 8; b >= 0; b--) expQ.push_back({frame[b], 1'b1, 1'b0, 2'(f)});
            if (f < int'(rep)) expQ.push_back({1'b0, 1'b1, 1'b0, 2'(f)});
          end
          expQ.push_back({1'b0, 1'b0, 1'b1, 2'd0});
        end
        if (expQ.size() > 0) cur = expQ.pop_front();
        else cur = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) checkOutput("cycle_outputs", 64'({ser, busy, done, fidx}), 64'(cur));
    end
  end

  // Drives one start pulse and records busy-cycle bits, timing and 1101 detections.
  task automatic applyStimulus(input logic [3:0] d, input logic [1:0] r, input bit noWait,
                               output logic [39:0] bits, output int busyCnt, output int firstBusy,
                               output int doneCyc, output logic [63:0] detMask);
    logic [2:0] hist;
    if (!noWait) @(negedge clk);
    hist      = {2'b00, ser};
    start     = 1'b1;
    data      = d;
    rep       = r;
    bits      = '0;
    busyCnt   = 0;
    firstBusy = -1;
    doneCyc   = -1;
    detMask   = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      data  = 4'($urandom);
      rep   = 2'($urandom);
      if ({hist, ser} == 4'b1101) detMask[c] = 1'b1;
      hist = {hist[1:0], ser};
      if (busy) begin
        bits = {bits[38:0], ser};
        busyCnt++;
        if (firstBusy < 0) firstBusy = c;
      end
      if (done) begin
        doneCyc = c;
        break;
      end
    end
  endtask

  initial begin
    logic [39:0] bits;
    logic [63:0] det;
    logic [28:0] expBits;
    int busyCnt, firstBusy, doneCyc;

    reset = 1'b1;
    start = 1'b0;
    data  = 4'd0;
    rep   = 2'd0;
    #1;
    checkOutput("reset_outputs", 64'({ser, busy, done, fidx}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(4'b1010, 2'd0, 1'b0, bits, busyCnt, firstBusy, doneCyc, det);
    checkOutput("frame_1010_bits", 64'(bits), 64'(9'b110110100));
    checkOutput("frame_1010_busy_cycles", 64'(busyCnt), 64'd9);
    checkOutput("frame_1010_first_busy", 64'(firstBusy), 64'd1);
    checkOutput("frame_1010_done_cycle", 64'(doneCyc), 64'd10);

    applyStimulus(4'b0111, 2'd0, 1'b0, bits, busyCnt, firstBusy, doneCyc, det);
    checkOutput("frame_0111_bits", 64'(bits), 64'(9'b110101111));
    checkOutput("frame_0111_done_cycle", 64'(doneCyc), 64'd10);

    applyStimulus(4'b0001, 2'd2, 1'b0, bits, busyCnt, firstBusy, doneCyc, det);
    expBits = {9'b110100011, 1'b0, 9'b110100011, 1'b0, 9'b110100011};
    checkOutput("burst3_bits", 64'(bits), 64'(expBits));
    checkOutput("burst3_busy_cycles", 64'(busyCnt), 64'd29);
    checkOutput("burst3_done_cycle", 64'(doneCyc), 64'd30);

    // Start is raised in the done cycle itself.
    applyStimulus(4'b1101, 2'd0, 1'b1, bits, busyCnt, firstBusy, doneCyc, det);
    checkOutput("b2b_first_busy", 64'(firstBusy), 64'd1);
    checkOutput("loopback_1101_bits", 64'(bits), 64'(9'b110111011));
    checkOutput("loopback_detections", det, (64'd1 << 4) | (64'd1 << 8));

    // Asynchronous reset in cycle 5 of a frame, with start held during reset.
    @(negedge clk);
    start = 1'b1;
    data  = 4'b1011;
    rep   = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_ser_c5", 64'({ser, busy}), 64'(2'b11));
    #1 reset = 1'b1;
    start = 1'b1;
    #1;
    checkOutput("async_reset_outputs", 64'({ser, busy, done, fidx}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", 64'({ser, busy, done}), 64'd0);

    applyStimulus(4'b1010, 2'd1, 1'b1, bits, busyCnt, firstBusy, doneCyc, det);
    checkOutput("post_reset_bits", 64'(bits), 64'({9'b110110100, 1'b0, 9'b110110100}));
    checkOutput("post_reset_busy_cycles", 64'(busyCnt), 64'd19);
    checkOutput("post_reset_done_cycle", 64'(doneCyc), 64'd20);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      data  = 4'($urandom);
      rep   = 2'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    // Start held high: bursts may only restart from the done cycle.
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      data = 4'($urandom);
      rep  = 2'($urandom);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
